sequenciador_canais: RTL and testbench
======================================

# sequenciador_canais

Round-robin conversion scheduler that sits in front of the dual-slope conversion control FSM and its counter. It selects one of N analog channels through the input mux, waits for the mux to settle, and pulses the conversion start. It then waits for end-of-conversion with a timeout and captures the count as a tagged result. It scans the enabled channels continuously while `en` is high.

## Interface
Parameters:
- `N_CH`, 4: number of analog channels (2..16).
- `CNT_W`, 12: width of the conversion count.
- `SETTLE_CYC`, 8: mux settling cycles before start (≥1).
- `TIMEOUT_CYC`, 4096: max cycles waiting for `conv_done` (≥4).

Ports:
- `ck` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: scan enable (level).
- `ch_mask` in N_CH: channel enable bits; bit i = channel i.
- `conv_done` in 1: one-cycle end-of-conversion pulse from the conversion FSM.
- `cnt_in` in CNT_W: conversion count, valid in the cycle `conv_done` is high.
- `inicio` out 1: conversion start request to the conversion FSM.
- `sel_ch` out $clog2(N_CH): analog mux select.
- `res_data` out CNT_W: captured result.
- `res_ch` out $clog2(N_CH): channel tag of `res_data`.
- `res_valid` out 1: one-cycle result strobe.
- `busy` out 1: high in every state except IDLE.
- `timeout_err` out 1: one-cycle strobe when a conversion timed out.

## Operation
- States and transitions:
  - IDLE → SELECT when `en` and `ch_mask != 0`.
  - SELECT (SETTLE_CYC cycles) → START.
  - START (exactly 2 cycles, `inicio` = 1) → WAIT.
  - WAIT → CAPTURE on `conv_done`; WAIT → NEXT on timeout.
  - CAPTURE (1 cycle) → NEXT.
  - NEXT (1 cycle) → SELECT if `en` and mask != 0; otherwise → IDLE.
- Outputs by state:
  - `inicio` is high only in START, so the conversion FSM sees a level spanning two rising and two falling edges.
  - `inicio` is low again before the conversion FSM returns to its start state, so a conversion never retriggers itself.
- Channel advance in NEXT: `sel_ch` takes the lowest enabled index strictly above the current channel, wrapping to the lowest enabled index. If the current channel is the only enabled one, `sel_ch` stays put.
- First entry from IDLE: `sel_ch` takes the lowest enabled index.
- Mask handling: `ch_mask` is sampled only in IDLE→SELECT and in NEXT. Changes during SELECT/START/WAIT do not abort the current conversion.
- Dropping `en` mid-scan: the current conversion completes, including result capture, then the block returns to IDLE.
- Timeout: the WAIT counter reaching TIMEOUT_CYC raises `timeout_err` for 1 cycle and produces no `res_valid`.
- Simultaneous events: if `conv_done` arrives in the same cycle as the timeout, `conv_done` wins and no error is reported.
- Spurious `conv_done`: ignored outside WAIT.
- Reset values: state = IDLE, `inicio` 0, `sel_ch` 0, `res_data` 0, `res_ch` 0, `res_valid` 0, `busy` 0, `timeout_err` 0, all counters 0. Reset mid-conversion drops `inicio` immediately (asynchronously).

## Timing
- All outputs are registered.
- Result latency: `conv_done` high at edge k → `res_data`/`res_ch`/`res_valid` valid in the cycle after edge k+1 (CAPTURE). `res_valid` is high for exactly 1 cycle.
- Channel-to-channel overhead, excluding conversion time: SETTLE_CYC + 2 (START) + 1 (CAPTURE) + 1 (NEXT) cycles.
- `sel_ch` is stable from SELECT entry through CAPTURE; it changes only on the NEXT edge.
- `timeout_err` is asserted in the cycle following the edge on which the counter hits TIMEOUT_CYC.

## Configuration
- Macro: `SEQ_MEDIA_EN`.
- Defined: each channel is converted 4 times back to back, looping WAIT→SELECT without advancing `sel_ch`. Counts are summed in a CNT_W+2 accumulator, and `res_data` = sum >> 2, truncated toward zero. `res_valid` fires once per 4 conversions. A timeout on any of the 4 conversions aborts the average for that channel (error strobe, no result), and the block advances.
- Undefined: one conversion per channel, and `res_data` = `cnt_in` unchanged.

## Structure
- Shared package `sequenciador_pkg`:
  - state enum (IDLE, SELECT, START, WAIT, CAPTURE, NEXT);
  - START length constant (2);
  - averaging depth constant (4) and its shift (2).
- One sub-module: `prox_canal`, a combinational next-enabled-channel finder (mask, current index → next index, any_enabled).
- The FSM, settle/timeout counters and result registers live in the top module.

## Test plan
- Mask 4'b1011, `en`=1, model returns `conv_done` 20 cycles after `inicio` falls with `cnt_in` = 100+ch → results tagged 0,1,3,0,… with data 100,101,103; `inicio` high exactly 2 cycles per conversion.
- Mask 4'b0000 with `en`=1 → stays IDLE, `busy`=0, `inicio` never asserted; then set mask 4'b0100 → converts channel 2 only, repeatedly.
- Model never returns `conv_done` on channel 1 → `timeout_err` pulse TIMEOUT_CYC+1 cycles after WAIT entry, no `res_valid`, scan continues to the next enabled channel.
- `conv_done` in the exact timeout cycle → `res_valid`=1, `timeout_err`=0.
- `en` dropped during WAIT → result still delivered, then IDLE. Async `rst` during START → `inicio`=0 before the next edge, and all outputs at their reset values.
- With `SEQ_MEDIA_EN`, counts 10,11,12,14 → single `res_valid` with `res_data`=11.

Source files
------------

// File: rtl/sequenciador_pkg.sv
// sequenciador_pkg: scan-state encoding and fixed timing constants shared by
// the channel sequencer and its helpers.
package sequenciador_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        START,
        WAIT,
        CAPTURE,
        NEXT
    } estado_t;

    // Cycles that the conversion start request stays high
    localparam int START_LEN   = 2;

    // Conversions accumulated per result when averaging, and the matching divide shift
    localparam int MEDIA_N     = 4;
    localparam int MEDIA_SHIFT = 2;

endpackage

// File: rtl/prox_canal.sv
// prox_canal: combinational finder for the next enabled channel above the
// current index, wrapping to the lowest enabled one.
module prox_canal #(
    parameter int N_CH  = 4,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  mask,
    input  logic [IDX_W-1:0] cur,
    output logic [IDX_W-1:0] nxt,
    output logic             any_enabled
);

    logic [IDX_W-1:0] acima;
    logic             tem_acima;
    logic [IDX_W-1:0] menor;

    // Walk from the top index down so the last hit is always the lowest candidate
    always_comb begin
        acima     = '0;
        tem_acima = 1'b0;
        menor     = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                menor = IDX_W'(i);
                if (i > int'(cur)) begin
                    acima     = IDX_W'(i);
                    tem_acima = 1'b1;
                end
            end
        end
    end

    assign any_enabled = |mask;
    assign nxt         = tem_acima ? acima : (any_enabled ? menor : cur);

endmodule

// File: rtl/sequenciador_canais.sv
// sequenciador_canais: round-robin scheduler for the dual-slope converter.
// Selects a channel, waits for the mux to settle, pulses inicio for two
// cycles, then waits (with timeout) for conv_done and publishes the count.
// Optional macro SEQ_MEDIA_EN: each channel is converted four times and the
// published result is the truncated average.
module sequenciador_canais
    import sequenciador_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 12,
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                      ck,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N_CH-1:0]           ch_mask,
    input  logic                      conv_done,
    input  logic [CNT_W-1:0]          cnt_in,
    output logic                      inicio,
    output logic [$clog2(N_CH)-1:0]   sel_ch,
    output logic [CNT_W-1:0]          res_data,
    output logic [$clog2(N_CH)-1:0]   res_ch,
    output logic                      res_valid,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IDX_W    = $clog2(N_CH);
    localparam int FASE_W   = $clog2(SETTLE_CYC + START_LEN) + 1;
    localparam int ESPERA_W = $clog2(TIMEOUT_CYC + 1);
`ifdef SEQ_MEDIA_EN
    localparam int ACC_W    = CNT_W + 2;
    localparam int MED_W    = $clog2(MEDIA_N);
`else
    localparam int ACC_W    = CNT_W;
`endif

    estado_t             estado;
    logic [FASE_W-1:0]   fase_cnt;
    logic [ESPERA_W-1:0] espera_cnt;
    logic [ACC_W-1:0]    acc;
`ifdef SEQ_MEDIA_EN
    logic [MED_W-1:0]    med_cnt;
`endif
    logic [IDX_W-1:0]    cur_busca;
    logic [IDX_W-1:0]    prox_idx;
    logic                tem_canal;

    // Searching above the top index wraps to the lowest enabled channel, which
    // is exactly the first channel wanted when leaving IDLE
    assign cur_busca = (estado == IDLE) ? IDX_W'(N_CH - 1) : sel_ch;

    prox_canal #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_prox (
        .mask        (ch_mask),
        .cur         (cur_busca),
        .nxt         (prox_idx),
        .any_enabled (tem_canal)
    );

    // Scan FSM with settle/start/wait counters and registered result outputs
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            estado      <= IDLE;
            inicio      <= 1'b0;
            sel_ch      <= '0;
            res_data    <= '0;
            res_ch      <= '0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            fase_cnt    <= '0;
            espera_cnt  <= '0;
            acc         <= '0;
`ifdef SEQ_MEDIA_EN
            med_cnt     <= '0;
`endif
        end else begin
            res_valid   <= 1'b0;
            timeout_err <= 1'b0;
            case (estado)
                IDLE: begin
                    if (en && tem_canal) begin
                        estado   <= SELECT;
                        sel_ch   <= prox_idx;
                        busy     <= 1'b1;
                        fase_cnt <= '0;
                    end
                end
                SELECT: begin
                    if (fase_cnt == FASE_W'(SETTLE_CYC - 1)) begin
                        estado   <= START;
                        inicio   <= 1'b1;
                        fase_cnt <= '0;
                    end else begin
                        fase_cnt <= fase_cnt + 1'b1;
                    end
                end
                START: begin
                    if (fase_cnt == FASE_W'(START_LEN - 1)) begin
                        estado     <= WAIT;
                        inicio     <= 1'b0;
                        fase_cnt   <= '0;
                        espera_cnt <= '0;
                    end else begin
                        fase_cnt <= fase_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (conv_done) begin
`ifdef SEQ_MEDIA_EN
                        acc <= acc + ACC_W'(cnt_in);
                        if (med_cnt == MED_W'(MEDIA_N - 1)) begin
                            med_cnt <= '0;
                            estado  <= CAPTURE;
                        end else begin
                            med_cnt <= med_cnt + 1'b1;
                            estado  <= SELECT;
                        end
`else
                        acc    <= cnt_in;
                        estado <= CAPTURE;
`endif
                    end else if (espera_cnt == ESPERA_W'(TIMEOUT_CYC)) begin
                        timeout_err <= 1'b1;
                        estado      <= NEXT;
                        acc         <= '0;
`ifdef SEQ_MEDIA_EN
                        med_cnt     <= '0;
`endif
                    end else begin
                        espera_cnt <= espera_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
`ifdef SEQ_MEDIA_EN
                    res_data <= CNT_W'(acc >> MEDIA_SHIFT);
`else
                    res_data <= acc;
`endif
                    res_ch    <= sel_ch;
                    res_valid <= 1'b1;
                    acc       <= '0;
                    estado    <= NEXT;
                end
                NEXT: begin
                    if (en && tem_canal) begin
                        sel_ch <= prox_idx;
                        estado <= SELECT;
                    end else begin
                        estado <= IDLE;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    estado <= IDLE;
                    busy   <= 1'b0;
                    inicio <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequenciador_canais.sv
// tb_sequenciador_canais: self-checking bench for the channel sequencer.
// A conversion-FSM stand-in answers each start request; a reference model of
// the scan order and result timing checks every strobe and tag.
// Honours SEQ_MEDIA_EN (four conversions averaged per result).
module tb_sequenciador_canais;

    localparam int N_CH        = 4;
    localparam int CNT_W       = 12;
    localparam int SETTLE_CYC  = 3;
    localparam int TIMEOUT_CYC = 40;
    localparam int IDX_W       = $clog2(N_CH);
`ifdef SEQ_MEDIA_EN
    localparam int CONV_POR_RES = 4;
`else
    localparam int CONV_POR_RES = 1;
`endif

    logic              ck = 1'b0;
    logic              rst;
    logic              en;
    logic [N_CH-1:0]   ch_mask;
    logic              conv_done;
    logic [CNT_W-1:0]  cnt_in;
    logic              inicio;
    logic [IDX_W-1:0]  sel_ch;
    logic [CNT_W-1:0]  res_data;
    logic [IDX_W-1:0]  res_ch;
    logic              res_valid;
    logic              busy;
    logic              timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    int  model_ch, grupo, soma, exp_data, data_v;
    int  cyc, res_at, to_at, rise_at, hi_len, cur_delay;
    int  results_seen = 0, timeouts_seen = 0, starts_seen = 0;
    int  resp_delay = 20, never_ch = -1, data_mode = 1;
    bit  model_restart = 1'b1, rand_delay = 1'b0, spur_on = 1'b0;
    bit  tracking, withhold, res_pending, to_pending, prev_inicio;
    int  med_q[$];

    sequenciador_canais #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .ck          (ck),
        .rst         (rst),
        .en          (en),
        .ch_mask     (ch_mask),
        .conv_done   (conv_done),
        .cnt_in      (cnt_in),
        .inicio      (inicio),
        .sel_ch      (sel_ch),
        .res_data    (res_data),
        .res_ch      (res_ch),
        .res_valid   (res_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // 10 ns clock
    always #5 ck = ~ck;

    function automatic int lowest_enabled(input logic [N_CH-1:0] m);
        for (int k = 0; k < N_CH; k++) if (m[k]) return k;
        return 0;
    endfunction

    function automatic int next_enabled(input int cur, input logic [N_CH-1:0] m);
        for (int k = 1; k <= N_CH; k++) if (m[(cur + k) % N_CH]) return (cur + k) % N_CH;
        return cur;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit e, input logic [N_CH-1:0] m);
        @(negedge ck);
        #1;
        en      = e;
        ch_mask = m;
    endtask

    task automatic startScan(input logic [N_CH-1:0] m);
        model_restart = 1'b1;
        rise_at       = -1;
        applyStimulus(1'b1, m);
    endtask

    task automatic waitResults(input int n, input int budget);
        int alvo;
        int k;
        alvo = results_seen + n;
        k    = 0;
        while (results_seen < alvo && k < budget) begin
            @(negedge ck); #1;
            k++;
        end
        if (results_seen < alvo) checkOutput("wait_results", results_seen, alvo);
    endtask

    task automatic waitTimeouts(input int n, input int budget);
        int alvo;
        int k;
        alvo = timeouts_seen + n;
        k    = 0;
        while (timeouts_seen < alvo && k < budget) begin
            @(negedge ck); #1;
            k++;
        end
        if (timeouts_seen < alvo) checkOutput("wait_timeouts", timeouts_seen, alvo);
    endtask

    task automatic waitIdle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge ck); #1;
            k++;
        end
        if (busy) checkOutput("wait_idle", busy, 0);
    endtask

    task automatic waitInicio(input logic lvl, input int budget);
        int k;
        k = 0;
        while (inicio !== lvl && k < budget) begin
            @(negedge ck); #1;
            k++;
        end
        if (inicio !== lvl) checkOutput("wait_inicio", inicio, lvl);
    endtask

    // Conversion stand-in plus reference model: answers start requests and
    // predicts every result/timeout strobe, channel tag and start spacing
    initial begin : monitor
        prev_inicio = 1'b0;
        tracking    = 1'b0;
        res_pending = 1'b0;
        to_pending  = 1'b0;
        rise_at     = -1;
        grupo       = 0;
        soma        = 0;
        model_ch    = 0;
        cyc         = 0;
        forever begin
            @(negedge ck);
            if (rst) begin
                conv_done     = 1'b0;
                prev_inicio   = 1'b0;
                hi_len        = 0;
                tracking      = 1'b0;
                res_pending   = 1'b0;
                to_pending    = 1'b0;
                grupo         = 0;
                soma          = 0;
                rise_at       = -1;
                model_restart = 1'b1;
            end else begin
                conv_done = 1'b0;
                if (tracking) cyc++;

                checkOutput("res_valid", res_valid, (res_pending && cyc == res_at));
                if (res_pending && cyc == res_at) begin
                    checkOutput("res_ch", res_ch, model_ch);
                    checkOutput("res_data", res_data, exp_data);
                    res_pending = 1'b0;
                    results_seen++;
                end
                checkOutput("timeout_err", timeout_err, (to_pending && cyc == to_at));
                if (to_pending && cyc == to_at) begin
                    to_pending = 1'b0;
                    timeouts_seen++;
                end

                if (tracking && !withhold && cyc == cur_delay) begin
                    case (data_mode)
                        1:       data_v = 100 + model_ch;
                        2:       data_v = (med_q.size() > 0) ? med_q.pop_front() : 0;
                        default: data_v = int'($urandom_range(0, 2**CNT_W - 1));
                    endcase
                    conv_done = 1'b1;
                    cnt_in    = CNT_W'(data_v);
                    soma     += data_v;
                    grupo++;
                    if (grupo == CONV_POR_RES) begin
                        res_pending = 1'b1;
                        res_at      = cyc + 2;
                        exp_data    = soma / CONV_POR_RES;
                        soma        = 0;
                        grupo       = 0;
                        rise_at     = cyc + 3 + SETTLE_CYC;
                    end else begin
                        rise_at     = cyc + 1 + SETTLE_CYC;
                    end
                end
                if (tracking && withhold && cyc == TIMEOUT_CYC) begin
                    to_pending = 1'b1;
                    to_at      = TIMEOUT_CYC + 1;
                    grupo      = 0;
                    soma       = 0;
                    rise_at    = TIMEOUT_CYC + 2 + SETTLE_CYC;
                end

                if (inicio) begin
                    if (!prev_inicio) begin
                        starts_seen++;
                        if (rise_at >= 0) checkOutput("start_gap", cyc, rise_at);
                        if (model_restart) begin
                            model_ch      = lowest_enabled(ch_mask);
                            model_restart = 1'b0;
                            grupo         = 0;
                            soma          = 0;
                        end else if (grupo == 0) begin
                            model_ch = next_enabled(model_ch, ch_mask);
                        end
                        checkOutput("sel_ch", sel_ch, model_ch);
                        checkOutput("busy_scan", busy, 1);
                        hi_len   = 0;
                        tracking = 1'b0;
                        if (spur_on) begin
                            conv_done = 1'b1;
                            cnt_in    = CNT_W'($urandom);
                        end
                    end
                    hi_len++;
                end else if (prev_inicio) begin
                    checkOutput("inicio_len", hi_len, 2);
                    tracking  = 1'b1;
                    cyc       = 0;
                    withhold  = (model_ch == never_ch);
                    cur_delay = rand_delay ? int'($urandom_range(1, TIMEOUT_CYC)) : resp_delay;
                end
                prev_inicio = inicio;
            end
        end
    end

    // Directed sequence of scenarios
    initial begin : stimulus
        int snap;
        logic [N_CH-1:0] m;
        rst       = 1'b1;
        en        = 1'b0;
        ch_mask   = '0;
        conv_done = 1'b0;
        cnt_in    = '0;
        repeat (2) @(negedge ck);
        checkOutput("rst_inicio", inicio, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sel_ch", sel_ch, 0);
        checkOutput("rst_res_data", res_data, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_timeout_err", timeout_err, 0);
        #1 rst = 1'b0;

        // Empty mask: stays idle
        applyStimulus(1'b1, 4'b0000);
        repeat (20) @(negedge ck);
        #1;
        checkOutput("empty_busy", busy, 0);
        checkOutput("empty_starts", starts_seen, 0);

        // Single channel repeats
        startScan(4'b0100);
        waitResults(3, 1500);
        applyStimulus(1'b0, 4'b0100);
        waitIdle(1500);

        // Round-robin with cnt_in = 100 + channel
        data_mode  = 1;
        resp_delay = 20;
        startScan(4'b1011);
        waitResults(5, 2000);

        // Channel 1 never answers
        never_ch = 1;
        waitTimeouts(2, 4000);
        never_ch = -1;
        waitResults(2, 2000);

        // conv_done in the exact timeout cycle
        resp_delay = TIMEOUT_CYC;
        waitResults(3, 3000);
        resp_delay = 20;

        // Randomized masks, delays, data, spurious conv_done in START
        rand_delay = 1'b1;
        spur_on    = 1'b1;
        data_mode  = 0;
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b0, ch_mask);
            waitIdle(2000);
            m = N_CH'($urandom_range(1, 2**N_CH - 1));
            startScan(m);
            waitResults(4, 4000);
        end
        rand_delay = 1'b0;
        spur_on    = 1'b0;
        data_mode  = 1;

        // en dropped during WAIT: result still arrives, then idle
        waitInicio(1'b1, 1000);
        waitInicio(1'b0, 100);
        applyStimulus(1'b0, ch_mask);
        waitResults(1, 1500);
        repeat (3) @(negedge ck);
        #1;
        checkOutput("drop_busy", busy, 0);
        snap = starts_seen;
        repeat (30) @(negedge ck);
        #1;
        checkOutput("drop_no_start", starts_seen, snap);

        // Asynchronous reset while inicio is high
        startScan(4'b1011);
        waitInicio(1'b1, 200);
        rst = 1'b1;
        #1;
        checkOutput("arst_inicio", inicio, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_sel_ch", sel_ch, 0);
        checkOutput("arst_res_data", res_data, 0);
        checkOutput("arst_res_ch", res_ch, 0);
        checkOutput("arst_res_valid", res_valid, 0);
        checkOutput("arst_timeout_err", timeout_err, 0);
        repeat (2) @(negedge ck);
        #1 rst = 1'b0;
        applyStimulus(1'b0, 4'b0000);

`ifdef SEQ_MEDIA_EN
        // Averaging of 10, 11, 12, 14 gives 11
        data_mode = 2;
        med_q     = {10, 11, 12, 14};
        startScan(4'b0001);
        waitResults(1, 1000);
        checkOutput("media_res", res_data, 11);
        applyStimulus(1'b0, 4'b0001);
        waitIdle(1000);
`endif

        repeat (5) @(negedge ck);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
